or_gate_arbiter: RTL and testbench
==================================

Name: or_gate_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2-input OR gate instance (ports a, b, c) among NREQ requesters.
- Each transaction runs in a fixed order: the block grants one requester, drives that requester's operands onto the shared gate, captures the gate output, and returns it with a one-cycle acknowledge.
- Sits between the requester blocks and the single or1 instance. The gate itself stays external and purely combinational.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- W, 1, operand/result width in bits; the shared gate is W bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level.
- a_in  input  NREQ*W  operand A; requester i uses bits [i*W +: W].
- b_in  input  NREQ*W  operand B; requester i uses bits [i*W +: W].
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- res  output  W  captured gate result.
- res_id  output  $clog2(NREQ)  index of the requester that owns res.
- gate_a  output  W  registered operand driven to shared gate input a.
- gate_b  output  W  registered operand driven to shared gate input b.
- gate_c  input  W  shared gate output c.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values (while rst_n=0): state=IDLE, ack=0, res=0, res_id=0, gate_a=0, gate_b=0, busy=0, round-robin pointer ptr=0. Reset asserted mid-transaction aborts it immediately and no ack is issued.
- FSM states are IDLE, EVAL, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select g = the first i with req[i]=1, searching ptr, ptr+1, ... modulo NREQ.
  - At that edge: gate_a<=a_in[g], gate_b<=b_in[g], res_id<=g, go to EVAL.
- EVAL:
  - gate_a/gate_b have been stable for one full cycle.
  - At the edge: res<=gate_c, ack[g]<=1, ptr<=(g+1) mod NREQ, go to DONE.
- DONE:
  - ack[g] is high for exactly this cycle.
  - At the edge: ack<=0, go to IDLE.
- Latency: req sampled at edge k gives ack high in the cycle after edge k+1. That is 2 cycles from sample to ack, and 3 cycles per transaction. The next arbitration happens at edge k+3 at the earliest.
- Handshake:
  - The requester holds req and its operands stable until it sees ack.
  - req is only sampled in IDLE.
  - If req is still high in the IDLE cycle after DONE, it counts as a new request.
- Operand changes after grant: gate_a/gate_b are latched at grant, so later changes to a_in/b_in are ignored.
- req dropped during EVAL/DONE: the transaction still completes and ack is still pulsed.
- Fairness: ptr advances past the last grantee. With all NREQ requests held high, grants rotate 0,1,...,NREQ-1,0.
- Output hold: res and res_id hold their values until the next EVAL capture.
- gate_a/gate_b hold their last operands while idle.
- Arithmetic: ptr wraps modulo NREQ. For non-power-of-2 NREQ, an explicit compare resets ptr to 0.

Optional Feature:
- Macro: OR_ARB_GRANT_CNT_EN.
- When defined:
  - Adds output grant_cnt, NREQ*8 bits: one 8-bit saturating counter per requester (holds at 255).
  - Counter i increments in the EVAL cycle when g=i.
  - Adds input cnt_clr (1 bit): synchronously zeroes all counters; if it coincides with an increment, clear wins.
  - All counters reset to 0 on rst_n=0.
- When undefined: neither port exists, there are no counter registers, and all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-EVAL with req=4'b0010 -> ack=0, busy=0, res=0, gate_a=gate_b=0 asynchronously, and no ack appears after release.
- Single request: req=4'b0100, a_in[2]=0, b_in[2]=1 -> ack=4'b0100 for exactly one cycle, 2 cycles after the sample edge; res=1, res_id=2.
- OR truth table via requester 0: operand pairs 00, 01, 10, 11 in turn -> res=0, 1, 1, 1, each with one ack pulse.
- Contention: req=4'b1111 held for 12 cycles -> ack sequence 0001, 0010, 0100, 1000, one every 3 cycles; no requester is granted twice before all have been granted.
- Withdraw and operand change: req[1] dropped and a_in[1] toggled during EVAL -> ack[1] still pulses, and res equals the OR of the operands latched at grant.
- Optional feature (OR_ARB_GRANT_CNT_EN): hold req[3]=1 for 300 transactions -> counter 3 saturates at 255; pulse cnt_clr -> all counters read 0 the next cycle.

Source files
------------

// File: rtl/or_gate_arbiter.sv
// -----------------------------------------------------------------------------
// or_gate_arbiter
// Round-robin arbiter/sequencer sharing one external combinational OR gate
// (inputs gate_a/gate_b, output gate_c) among NREQ requesters. Each
// transaction is IDLE (grant + latch operands) -> EVAL (capture gate_c) ->
// DONE (one-cycle ack pulse), three cycles in total.
//
// Optional build macro: OR_ARB_GRANT_CNT_EN adds per-requester 8-bit
// saturating grant counters (grant_cnt) with a synchronous clear (cnt_clr).
// -----------------------------------------------------------------------------
module or_gate_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*W-1:0]         a_in,
    input  logic [NREQ*W-1:0]         b_in,
    output logic [NREQ-1:0]           ack,
    output logic [W-1:0]              res,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic [W-1:0]              gate_a,
    output logic [W-1:0]              gate_b,
    input  logic [W-1:0]              gate_c,
    output logic                      busy
`ifdef OR_ARB_GRANT_CNT_EN
    ,
    input  logic                      cnt_clr,
    output logic [NREQ*8-1:0]         grant_cnt
`endif
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    gate_a_q, gate_a_d;
    logic [W-1:0]    gate_b_q, gate_b_d;
    logic [NREQ-1:0] ack_q, ack_d;

    logic [IDW-1:0]  grant_idx;
    logic            grant_found;

    // Index ptr+k wrapped into 0..NREQ-1 by an explicit compare, so
    // non-power-of-2 NREQ wraps correctly.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Round-robin search: first active request starting at ptr.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req[rr_index(ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(ptr_q, k);
            end
        end
    end

    // Next-state and next-register values for the three-phase sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        res_id_d = res_id_q;
        res_d    = res_q;
        gate_a_d = gate_a_q;
        gate_b_d = gate_b_q;
        ack_d    = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    gate_a_d = a_in[int'(grant_idx)*W +: W];
                    gate_b_d = b_in[int'(grant_idx)*W +: W];
                    res_id_d = grant_idx;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                // Operands have been on the gate for a full cycle; sample it.
                res_d            = gate_c;
                ack_d[res_id_q]  = 1'b1;
                ptr_d            = (res_id_q == IDW'(NREQ-1)) ? '0 : res_id_q + 1'b1;
                state_d          = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            res_id_q <= '0;
            res_q    <= '0;
            gate_a_q <= '0;
            gate_b_q <= '0;
            ack_q    <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            res_id_q <= res_id_d;
            res_q    <= res_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
            ack_q    <= ack_d;
        end
    end

    assign ack    = ack_q;
    assign res    = res_q;
    assign res_id = res_id_q;
    assign gate_a = gate_a_q;
    assign gate_b = gate_b_q;
    assign busy   = (state_q != IDLE);

`ifdef OR_ARB_GRANT_CNT_EN
    logic [7:0] cnt_q [NREQ];

    // Per-requester saturating grant counters; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (state_q == EVAL && res_id_q == IDW'(i) && cnt_q[i] != 8'hFF) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Flatten counters onto the output bus, requester i at bits [i*8 +: 8].
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) grant_cnt[i*8 +: 8] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_or_gate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_or_gate_arbiter
// Scoreboard bench: a transaction-level model predicts each grant (owner,
// OR result, ack cycle) and queues it; a monitor pops on every ack.
// Define OR_ARB_GRANT_CNT_EN to also exercise the grant counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_or_gate_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 1;
    localparam int IDW  = $clog2(NREQ);

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*W-1:0]     a_in;
    logic [NREQ*W-1:0]     b_in;
    logic [NREQ-1:0]       ack;
    logic [W-1:0]          res;
    logic [IDW-1:0]        res_id;
    logic [W-1:0]          gate_a;
    logic [W-1:0]          gate_b;
    logic [W-1:0]          gate_c;
    logic                  busy;
`ifdef OR_ARB_GRANT_CNT_EN
    logic                  cnt_clr;
    logic [NREQ*8-1:0]     grant_cnt;
`endif

    or_gate_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .ack      (ack),
        .res      (res),
        .res_id   (res_id),
        .gate_a   (gate_a),
        .gate_b   (gate_b),
        .gate_c   (gate_c),
        .busy     (busy)
`ifdef OR_ARB_GRANT_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .grant_cnt(grant_cnt)
`endif
    );

    // The shared external gate.
    assign gate_c = gate_a | gate_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          g;
        logic [W-1:0] r;
        longint      cyc;
    } exp_t;

    exp_t            sbq[$];
    logic [NREQ-1:0] ack_log[$];
    longint          cyc = 0;
    int              busy_cnt;   // cycles of the current transaction still to run
    int              mptr;
    int              m_g;
    int              exp_cnt [NREQ];

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
            mptr     <= 0;
            m_g      <= 0;
            sbq.delete();
            for (int i = 0; i < NREQ; i++) exp_cnt[i] <= 0;
        end else begin
            cyc <= cyc + 1;
`ifdef OR_ARB_GRANT_CNT_EN
            for (int i = 0; i < NREQ; i++) begin
                if (cnt_clr) exp_cnt[i] <= 0;
                else if (busy_cnt == 2 && i == m_g && exp_cnt[i] < 255) exp_cnt[i] <= exp_cnt[i] + 1;
            end
`endif
            if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
            end else if (req != '0) begin
                sbq.push_back('{g: pick(req, mptr),
                                r: a_in[pick(req, mptr)*W +: W] | b_in[pick(req, mptr)*W +: W],
                                cyc: cyc + 2});
                m_g      <= pick(req, mptr);
                mptr     <= (pick(req, mptr) + 1) % NREQ;
                busy_cnt <= 2;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, busy_cnt != 0);
            if (ack != '0) begin
                ack_log.push_back(ack);
                if (sbq.size() == 0) begin
                    check("ack_unexpected", ack, 0);
                end else begin
                    check("ack_onehot", ack, 64'd1 << sbq[0].g);
                    check("res", res, sbq[0].r);
                    check("res_id", res_id, sbq[0].g);
                    check("ack_cycle", cyc, sbq[0].cyc);
                    void'(sbq.pop_front());
                end
            end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                check("ack_missing", ack, 64'd1 << sbq[0].g);
                void'(sbq.pop_front());
            end
`ifdef OR_ARB_GRANT_CNT_EN
            for (int i = 0; i < NREQ; i++) check("grant_cnt", grant_cnt[i*8 +: 8], exp_cnt[i]);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input string name, input int i, input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (ack[i]) break;
        end
        check(name, ack[i], 1'b1);
    endtask

    task automatic wait_busy(input string name, input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (busy) break;
        end
        check(name, busy, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
`ifdef OR_ARB_GRANT_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_res", res, 0);
        check("rst_res_id", res_id, 0);
        check("rst_gate_a", gate_a, 0);
        check("rst_gate_b", gate_b, 0);
        rst_n = 1'b1;

        // Single request from requester 2: 0|1.
        @(negedge clk);
        req = 4'b0100; a_in[2] = 1'b0; b_in[2] = 1'b1;
        wait_ack("single_ack", 2, 10);
        check("single_res", res, 1);
        check("single_res_id", res_id, 2);
        req = '0;

        // OR truth table through requester 0.
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            a_in[0] = p[1]; b_in[0] = p[0]; req = 4'b0001;
            wait_ack("tt_ack", 0, 10);
            check("tt_res", res, (p != 0));
            req = '0;
        end

        // Reset asserted mid-EVAL aborts the transaction.
        @(negedge clk);
        req = 4'b0010; a_in[1] = 1'b1; b_in[1] = 1'b1;
        wait_busy("rst_mid_busy", 10);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", ack, 0);
        check("rst_mid_busy0", busy, 0);
        check("rst_mid_res", res, 0);
        check("rst_mid_gate_a", gate_a, 0);
        check("rst_mid_gate_b", gate_b, 0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_log.delete();
        repeat (6) @(negedge clk);
        check("rst_mid_no_ack", ack_log.size(), 0);

        // Contention: all four held for 12 cycles, pointer starts at 0.
        ack_log.delete();
        for (int i = 0; i < NREQ*W; i++) begin a_in[i] = 1'($urandom); b_in[i] = 1'($urandom); end
        req = 4'b1111;
        repeat (12) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        check("rr_count", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) check("rr_order", ack_log[i], 64'd1 << i);

        // Withdraw request and change operand during EVAL.
        @(negedge clk);
        req = 4'b0010; a_in[1] = 1'b0; b_in[1] = 1'b0;
        wait_busy("wd_busy", 10);
        req[1] = 1'b0; a_in[1] = 1'b1;
        wait_ack("wd_ack", 1, 5);
        check("wd_res", res, 0);
        check("wd_res_id", res_id, 1);

        // Randomized traffic; each requester holds until acknowledged.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] || !req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        a_in[i*W +: W] = W'($urandom);
                        b_in[i*W +: W] = W'($urandom);
                    end else if (ack[i]) begin
                        req[i] = 1'b0;
                    end
                end
            end
        end
        req = '0;
        repeat (6) @(negedge clk);
        check("drain_rand", sbq.size(), 0);

`ifdef OR_ARB_GRANT_CNT_EN
        // Saturate counter 3, then clear everything.
        begin
            int n;
            n = 0;
            req = 4'b1000; a_in[3] = 1'b1; b_in[3] = 1'b0;
            for (int c = 0; c < 1200 && n < 300; c++) begin
                @(negedge clk);
                if (ack[3]) n++;
            end
            req = '0;
            check("cnt_acks", n, 300);
            check("cnt3_sat", grant_cnt[3*8 +: 8], 255);
            @(negedge clk);
            cnt_clr = 1'b1;
            @(negedge clk);
            cnt_clr = 1'b0;
            check("cnt_clr", grant_cnt, 0);
        end
`endif

        repeat (4) @(negedge clk);
        check("drain_final", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
